// File: rtl/noc_pkt_pkg.sv
// rtl/noc_pkt_pkg.sv - NoC packet layout, packet type codes and accumulator FSM states
package noc_pkt_pkg;

    localparam int PKT_W = 18;

    typedef enum logic [1:0] {
        PKT_RSVD    = 2'b00,
        PKT_PSUM    = 2'b01,
        PKT_WR_ADDR = 2'b10,
        PKT_WR_DATA = 2'b11
    } pkt_type_e;

    typedef struct packed {
        logic [3:0] dst;
        logic [3:0] idx;
        pkt_type_e  pkt_type;
        logic [7:0] value;
    } noc_pkt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND_ADDR,
        ST_SEND_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/psum_adder.sv
// rtl/psum_adder.sv - 8-bit partial-sum adder; wraps modulo 256, saturates at 255 when PSUM_SAT_EN is defined
module psum_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum
);

`ifdef PSUM_SAT_EN
    logic [8:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[8] ? 8'hFF : full[7:0];
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - collects NUM_PE partial sums per pixel and writes each result to memory over the NoC
// Saturating accumulation is selected by defining PSUM_SAT_EN (see psum_adder).
module psum_accumulator
    import noc_pkt_pkg::*;
#(
    parameter logic [3:0] NODE_ADDR   = 4'd13,
    parameter logic [3:0] MEM_ADDR    = 4'd1,
    parameter int         NUM_PE      = 5,
    parameter int         NUM_OUT     = 9,
    parameter logic [7:0] RESULT_BASE = 8'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_pkt,
    output logic             done,
    output logic             err
);

    localparam logic [15:0] FULL_MASK = 16'((32'd1 << NUM_PE) - 32'd1);
    localparam logic [4:0]  NUM_PE_W  = 5'(NUM_PE);
    localparam logic [7:0]  LAST_PIX  = 8'(NUM_OUT - 1);

    state_e      state;
    logic [15:0] bitmap;
    logic [7:0]  acc;
    logic [7:0]  acc_next;
    logic [7:0]  pixel;

    noc_pkt_t    pkt;
    logic [15:0] idx_bit;
    logic        is_psum;
    logic        dup;
    logic        take;

    assign pkt     = noc_pkt_t'(in_pkt);
    assign idx_bit = 16'd1 << pkt.idx;
    assign is_psum = (pkt.dst == NODE_ADDR) && (pkt.pkt_type == PKT_PSUM) &&
                     ({1'b0, pkt.idx} < NUM_PE_W);

    // A repeat of an already-collected index is back-pressured, not dropped,
    // so it lands in the next pixel once the bitmap is cleared.
    assign dup      = in_valid && is_psum && ((bitmap & idx_bit) != 16'd0);
    assign in_ready = (state == ST_COLLECT) && !dup;
    assign take     = in_valid && in_ready;

    psum_adder u_adder (
        .a   (acc),
        .b   (pkt.value),
        .sum (acc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bitmap    <= 16'd0;
            acc       <= 8'd0;
            pixel     <= 8'd0;
            out_valid <= 1'b0;
            out_pkt   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= ST_COLLECT;
                        pixel  <= 8'd0;
                        bitmap <= 16'd0;
                        acc    <= 8'd0;
                    end
                end
                ST_COLLECT: begin
                    if (take) begin
                        if (is_psum) begin
                            acc    <= acc_next;
                            bitmap <= bitmap | idx_bit;
                            if (((bitmap | idx_bit) & FULL_MASK) == FULL_MASK) begin
                                state     <= ST_SEND_ADDR;
                                out_valid <= 1'b1;
                                out_pkt   <= {MEM_ADDR, NODE_ADDR, PKT_WR_ADDR,
                                              8'(RESULT_BASE + pixel)};
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SEND_ADDR: begin
                    if (out_ready) begin
                        state   <= ST_SEND_DATA;
                        out_pkt <= {MEM_ADDR, NODE_ADDR, PKT_WR_DATA, acc};
                    end
                end
                ST_SEND_DATA: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pixel     <= pixel + 8'd1;
                        bitmap    <= 16'd0;
                        acc       <= 8'd0;
                        if (pixel == LAST_PIX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
